uart_rx_master: RTL and testbench

//  UART receiver: the receive-side counterpart of the UART_TX_MASTER transmitter.
//  It samples the asynchronous serial line with a 16x oversampling baud tick and

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_baud_tick_gen.sv | 38 +++
 rtl/uart_rx_master.sv | 124 ++++++++++++
 tb/tb_uart_rx_master.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART receive types and constants
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } uart_rx_state_t;

endpackage

// File: rtl/uart_baud_tick_gen.sv
// rtl/uart_baud_tick_gen.sv - oversampling baud tick, one clk pulse per bit/OVERSAMPLING
module uart_baud_tick_gen #(
  parameter int CLK_FREQUENCY = 100000000,
  parameter int BAUD_RATE     = 115200,
  parameter int OVERSAMPLING  = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int TICK_DIV = (CLK_FREQUENCY / (BAUD_RATE * OVERSAMPLING) > 0) ?
                            CLK_FREQUENCY / (BAUD_RATE * OVERSAMPLING) : 1;
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (enable) begin
      if (cnt == CNT_LAST) begin
        cnt  <= '0;
        tick <= 1'b1;
      end else begin
        cnt  <= cnt + CW'(1);
        tick <= 1'b0;
      end
    end else begin
      cnt  <= '0;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx_master.sv
// rtl/uart_rx_master.sv - 8N1 UART receiver with 16x oversampling and framing-error flag
module uart_rx_master
  import uart_pkg::*;
#(
  parameter int CLK_FREQUENCY = 100000000,
  parameter int BAUD_RATE     = 115200,
  parameter int OVERSAMPLING  = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rx,
  output logic [UART_DATA_BITS-1:0] rx_data,
  output logic                      rx_valid,
  output logic                      rx_frame_err,
  output logic                      rx_busy
);

  localparam int SW = $clog2(OVERSAMPLING);
  localparam logic [SW-1:0] SCNT_MID = SW'(OVERSAMPLING / 2 - 1);
  localparam logic [SW-1:0] SCNT_END = SW'(OVERSAMPLING - 1);

  logic                      tick;
  logic                      rx_meta;
  logic                      rx_s;
  logic [SW-1:0]             scnt;
  logic [2:0]                bit_idx;
  logic [UART_DATA_BITS-1:0] shreg;
  uart_rx_state_t            state;

  uart_baud_tick_gen #(
    .CLK_FREQUENCY(CLK_FREQUENCY),
    .BAUD_RATE    (BAUD_RATE),
    .OVERSAMPLING (OVERSAMPLING)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .enable(1'b1),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta      <= 1'b1;
      rx_s         <= 1'b1;
      state        <= RX_IDLE;
      scnt         <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_busy      <= 1'b0;
    end else begin
      rx_meta      <= rx;
      rx_s         <= rx_meta;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      if (tick) begin
        case (state)
          RX_IDLE: begin
            if (!rx_s) begin
              state   <= RX_START;
              scnt    <= '0;
              rx_busy <= 1'b1;
            end
          end
          RX_START: begin
            // Re-check the line at mid start bit to reject short glitches.
            if (scnt == SCNT_MID) begin
              if (!rx_s) begin
                state   <= RX_DATA;
                scnt    <= '0;
                bit_idx <= '0;
              end else begin
                state   <= RX_IDLE;
                rx_busy <= 1'b0;
              end
            end else begin
              scnt <= scnt + SW'(1);
            end
          end
          RX_DATA: begin
            if (scnt == SCNT_END) begin
              shreg   <= {rx_s, shreg[UART_DATA_BITS-1:1]};
              scnt    <= '0;
              bit_idx <= bit_idx + 3'd1;
              if (bit_idx == 3'd7) state <= RX_STOP;
            end else begin
              scnt <= scnt + SW'(1);
            end
          end
          RX_STOP: begin
            if (scnt == SCNT_END) begin
              scnt <= '0;
              if (rx_s) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
                state    <= RX_IDLE;
                rx_busy  <= 1'b0;
              end else begin
                rx_frame_err <= 1'b1;
                state        <= RX_BREAK;
              end
            end else begin
              scnt <= scnt + SW'(1);
            end
          end
          RX_BREAK: begin
            // Hold here while the line stays low so a break cannot start a new frame.
            if (rx_s) begin
              state   <= RX_IDLE;
              rx_busy <= 1'b0;
            end
          end
          default: begin
            state   <= RX_IDLE;
            rx_busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_master.sv
// tb/tb_uart_rx_master.sv - randomized self-checking bench against an expected-event model
`timescale 1ns/1ps
module tb_uart_rx_master;

  localparam int  CLK_FREQ = 100000000;
  localparam int  BAUD     = 1562500;
  localparam int  OS       = 16;
  localparam real BIT_NS   = 1.0e9 / BAUD;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_busy;

  int n_tests = 0;
  int n_fail  = 0;
  int both_cnt = 0;

  // Events: bit 8 = framing error, bits 7:0 = received byte.
  logic [8:0] exp_q[$];
  logic [8:0] obs_q[$];
  logic [7:0] last_good = 8'h00;

  always #5 clk = ~clk;

  uart_rx_master #(
    .CLK_FREQUENCY(CLK_FREQ),
    .BAUD_RATE    (BAUD),
    .OVERSAMPLING (OS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_frame_err(rx_frame_err),
    .rx_busy     (rx_busy)
  );

  always @(negedge clk) begin
    if (!reset) begin
      if (rx_valid)     obs_q.push_back({1'b0, rx_data});
      if (rx_frame_err) obs_q.push_back(9'h100);
      if (rx_valid && rx_frame_err) both_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input real bt);
    rx = 1'b0;
    #(bt);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      #(bt);
    end
    rx = stop_ok;
    #(bt);
    if (stop_ok) begin
      exp_q.push_back({1'b0, d});
      last_good = d;
    end else begin
      exp_q.push_back(9'h100);
    end
  endtask

  task automatic compare_events(input string tag);
    check($sformatf("%s.count", tag), obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check($sformatf("%s.ev%0d", tag, i), obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    last_good = 8'h00;
  endtask

  initial begin
    real bt;
    logic [7:0] d;
    bit ok;
    logic [7:0] abort_byte;
    real rates[3];

    abort_byte = 8'h5A;
    rates[0] = BIT_NS;
    rates[1] = BIT_NS * 1.02;
    rates[2] = BIT_NS * 0.98;

    repeat (5) @(posedge clk);
    #1 reset = 1'b0;
    #(2.0 * BIT_NS);
    @(negedge clk);
    check("reset.valid", rx_valid, 0);
    check("reset.ferr", rx_frame_err, 0);
    check("reset.busy", rx_busy, 0);
    check("reset.data", rx_data, 8'h00);

    #2;
    send_frame(8'hA5, 1'b1, BIT_NS);
    #(BIT_NS);
    @(negedge clk);
    compare_events("a5");
    check("a5.busy", rx_busy, 0);
    check("a5.data", rx_data, 8'hA5);

    send_frame(8'h00, 1'b1, BIT_NS);
    send_frame(8'hFF, 1'b1, BIT_NS);
    #(BIT_NS);
    @(negedge clk);
    compare_events("b2b");
    check("b2b.data", rx_data, last_good);

    rx = 1'b0;
    #150;
    rx = 1'b1;
    #(2.0 * BIT_NS);
    @(negedge clk);
    compare_events("glitch");
    check("glitch.busy", rx_busy, 0);

    send_frame(8'h3C, 1'b0, BIT_NS);
    #(1.5 * BIT_NS);
    @(negedge clk);
    check("ferr.busy_low", rx_busy, 1);
    #(1.5 * BIT_NS);
    @(negedge clk);
    check("ferr.busy_held", rx_busy, 1);
    compare_events("ferr");
    check("ferr.data", rx_data, last_good);
    rx = 1'b1;
    #(BIT_NS);
    @(negedge clk);
    check("ferr.busy_rel", rx_busy, 0);

    for (int r = 0; r < 3; r++) begin
      bt = rates[r];
      rx = 1'b0;
      #(bt);
      for (int i = 0; i < 4; i++) begin
        rx = abort_byte[i];
        #(bt);
      end
      rx = abort_byte[4];
      #(bt / 2.0);
      do_reset();
      rx = 1'b1;
      @(negedge clk);
      check($sformatf("abort%0d.busy", r), rx_busy, 0);
      #(2.0 * bt);
      send_frame(8'hC3, 1'b1, bt);
      #(bt);
      @(negedge clk);
      compare_events($sformatf("abort%0d", r));
      check($sformatf("abort%0d.data", r), rx_data, 8'hC3);
    end

    for (int n = 0; n < 30; n++) begin
      d  = 8'($urandom);
      ok = ($urandom_range(0, 4) != 0);
      bt = BIT_NS * (0.98 + 0.04 * ($urandom_range(0, 1000) / 1000.0));
      send_frame(d, ok, bt);
      if (!ok) begin
        #(bt * $urandom_range(0, 1));
        rx = 1'b1;
        #(bt);
      end else begin
        #(bt * $urandom_range(0, 2));
      end
    end
    #(BIT_NS);
    @(negedge clk);
    compare_events("rand");
    check("rand.data", rx_data, last_good);
    check("rand.busy", rx_busy, 0);
    check("exclusive", both_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
